// File: rtl/rom_dl_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// dl_pkg
// Shared types for the ROM download controller: the region each ioctl byte
// belongs to, the FIFO entry that carries a byte from capture to issue, the
// controller state encoding, and the helper that decodes a byte address into
// its region.
// ---------------------------------------------------------------------------
package dl_pkg;

    typedef enum logic [1:0] {
        RGN_GFX  = 2'd0,
        RGN_CPU  = 2'd1,
        RGN_PAL  = 2'd2,
        RGN_DROP = 2'd3
    } region_t;

    typedef struct packed {
        region_t     region;
        logic [24:0] addr;
        logic [7:0]  data;
    } entry_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } dl_state_t;

    localparam logic [24:0] CPU_LEN = 25'h10000;
    localparam logic [24:0] PAL_LEN = 25'd32;

    // Region decode. The comparisons are done one bit wider so that a base
    // placed near the top of the address space cannot wrap its end bound.
    function automatic region_t decodeRegion(
        input logic [24:0] addr,
        input logic [24:0] cpuBase,
        input logic [24:0] palBase
    );
        logic [25:0] wideAddr;
        logic [25:0] cpuEnd;
        logic [25:0] palEnd;
        region_t     rgn;
        wideAddr = {1'b0, addr};
        cpuEnd   = {1'b0, cpuBase} + {1'b0, CPU_LEN};
        palEnd   = {1'b0, palBase} + {1'b0, PAL_LEN};
        if (addr < cpuBase) begin
            rgn = RGN_GFX;
        end else if (wideAddr < cpuEnd) begin
            rgn = RGN_CPU;
        end else if ((addr >= palBase) && (wideAddr < palEnd)) begin
            rgn = RGN_PAL;
        end else begin
            rgn = RGN_DROP;
        end
        return rgn;
    endfunction

endpackage

// File: rtl/rom_dl_ctrl_fifo.sv
// ---------------------------------------------------------------------------
// dl_fifo
// Small synchronous FIFO of download entries.
//   i_clk_sys   system clock
//   i_reset     synchronous active-high reset, empties the FIFO
//   i_push      write i_entry (accepted when not full, or full but popping)
//   i_entry     entry to write
//   i_pop       remove the head entry (ignored when empty)
//   o_head      current head entry (valid when o_empty is low)
//   o_full      all DEPTH slots occupied
//   o_empty     no entries stored
// ---------------------------------------------------------------------------
module dl_fifo
    import dl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   i_clk_sys,
    input  logic   i_reset,
    input  logic   i_push,
    input  entry_t i_entry,
    input  logic   i_pop,
    output entry_t o_head,
    output logic   o_full,
    output logic   o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    entry_t        r_mem [DEPTH];
    logic [AW:0]   r_wrPtr;
    logic [AW:0]   r_rdPtr;
    logic          w_doPop;
    logic          w_doPush;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign o_empty  = (r_wrPtr == r_rdPtr);
    assign o_full   = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                      (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
    assign w_doPop  = i_pop && !o_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_doPush = i_push && (!o_full || w_doPop);
    assign o_head   = r_mem[r_rdPtr[AW-1:0]];

    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk_sys) begin
        if (w_doPush) begin
            r_mem[r_wrPtr[AW-1:0]] <= i_entry;
        end
    end

endmodule

// File: rtl/rom_dl_ctrl.sv
// ---------------------------------------------------------------------------
// rom_dl_ctrl
// Sequences the ioctl ROM download stream into the SDRAM download ports
// (port1 = CPU ROM, port2 = GFX ROM) and the palette PROM write strobe, and
// owns the rom_loaded flag and the core reset.
//   i_clk_sys, i_reset          clock, synchronous active-high reset
//   i_user_reset                OSD/button reset request
//   i_ioctl_downl/wr/addr/dout  ioctl download stream (wr rising edge = byte)
//   o_port1_* / i_port1_ack     toggle-handshake CPU ROM write port
//   o_port2_* / i_port2_ack     toggle-handshake GFX ROM write port
//   o_pal_wr/addr/dat           one-cycle palette PROM write
//   o_rom_loaded                sticky: a download finished and drained
//   o_core_reset                reset to the game core
//   o_busy                      FIFO non-empty or a port request pending
//   o_overflow                  sticky: a byte was dropped on a full FIFO
// ---------------------------------------------------------------------------
module rom_dl_ctrl
    import dl_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [24:0] CPU_BASE   = 25'h10000,
    parameter logic [24:0] PAL_BASE   = 25'h20000
) (
    input  logic        i_clk_sys,
    input  logic        i_reset,
    input  logic        i_user_reset,
    input  logic        i_ioctl_downl,
    input  logic        i_ioctl_wr,
    input  logic [24:0] i_ioctl_addr,
    input  logic [7:0]  i_ioctl_dout,
    output logic        o_port1_req,
    input  logic        i_port1_ack,
    output logic [22:0] o_port1_a,
    output logic [1:0]  o_port1_ds,
    output logic [15:0] o_port1_d,
    output logic        o_port2_req,
    input  logic        i_port2_ack,
    output logic [22:0] o_port2_a,
    output logic [1:0]  o_port2_ds,
    output logic [15:0] o_port2_d,
    output logic        o_pal_wr,
    output logic [4:0]  o_pal_addr,
    output logic [7:0]  o_pal_dat,
    output logic        o_rom_loaded,
    output logic        o_core_reset,
    output logic        o_busy,
    output logic        o_overflow
);

    dl_state_t   r_state;
    dl_state_t   w_stateNext;
    logic        r_downlPrev;
    logic        r_wrPrev;
    logic        r_capValid;
    entry_t      r_capEntry;

    logic        r_port1Req;
    logic [22:0] r_port1A;
    logic [1:0]  r_port1Ds;
    logic [15:0] r_port1D;
    logic        r_port2Req;
    logic [22:0] r_port2A;
    logic [1:0]  r_port2Ds;
    logic [15:0] r_port2D;
    logic        r_palWr;
    logic [4:0]  r_palAddr;
    logic [7:0]  r_palDat;
    logic        r_romLoaded;
    logic        r_coreReset;
    logic        r_overflow;

    logic        w_capEdge;
    region_t     w_capRegion;
    logic        w_downlRise;
    logic        w_downlFall;
    entry_t      w_head;
    logic        w_fifoFull;
    logic        w_fifoEmpty;
    logic        w_pop;
    logic        w_port1Idle;
    logic        w_port2Idle;
    logic        w_drained;
    logic [24:0] w_cpuOff;
    logic        w_setLoaded;
    logic        w_coreResetNext;
    logic        w_unused;

    assign w_capEdge   = i_ioctl_wr && !r_wrPrev && i_ioctl_downl;
    assign w_capRegion = decodeRegion(i_ioctl_addr, CPU_BASE, PAL_BASE);
    assign w_downlRise = i_ioctl_downl && !r_downlPrev;
    assign w_downlFall = !i_ioctl_downl && r_downlPrev;
    assign w_port1Idle = (r_port1Req == i_port1_ack);
    assign w_port2Idle = (r_port2Req == i_port2_ack);
    assign w_cpuOff    = w_head.addr - CPU_BASE;
    // A byte still sitting in the capture register counts as not drained.
    assign w_drained   = w_fifoEmpty && !r_capValid && w_port1Idle && w_port2Idle;
    assign w_unused    = w_cpuOff[24];

    // Byte capture: decode the region on the ioctl_wr rising edge and hand
    // the entry to the FIFO one cycle later. Out-of-range bytes never enter.
    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_wrPrev   <= i_ioctl_wr;
            r_capValid <= 1'b0;
            r_capEntry <= '0;
        end else begin
            r_wrPrev          <= i_ioctl_wr;
            r_capValid        <= w_capEdge && (w_capRegion != RGN_DROP);
            r_capEntry.region <= w_capRegion;
            r_capEntry.addr   <= i_ioctl_addr;
            r_capEntry.data   <= i_ioctl_dout;
        end
    end

    dl_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk_sys (i_clk_sys),
        .i_reset   (i_reset),
        .i_push    (r_capValid),
        .i_entry   (r_capEntry),
        .i_pop     (w_pop),
        .o_head    (w_head),
        .o_full    (w_fifoFull),
        .o_empty   (w_fifoEmpty)
    );

    // The head only leaves when its destination can take it, which keeps
    // the stream in order. Palette writes never stall.
    always_comb begin
        w_pop = 1'b0;
        if (!w_fifoEmpty) begin
            case (w_head.region)
                RGN_GFX: w_pop = w_port2Idle;
                RGN_CPU: w_pop = w_port1Idle;
                default: w_pop = 1'b1;
            endcase
        end
    end

    // Issue: the pop edge loads the port outputs and toggles req together, so
    // the SDRAM side sees stable address/data for the whole request.
    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_port1Req <= i_port1_ack;
            r_port1A   <= '0;
            r_port1Ds  <= '0;
            r_port1D   <= '0;
            r_port2Req <= i_port2_ack;
            r_port2A   <= '0;
            r_port2Ds  <= '0;
            r_port2D   <= '0;
            r_palWr    <= 1'b0;
            r_palAddr  <= '0;
            r_palDat   <= '0;
        end else begin
            r_palWr <= 1'b0;
            if (w_pop) begin
                case (w_head.region)
                    RGN_CPU: begin
                        r_port1A   <= w_cpuOff[23:1];
                        r_port1Ds  <= {w_cpuOff[0], ~w_cpuOff[0]};
                        r_port1D   <= {w_head.data, w_head.data};
                        r_port1Req <= ~r_port1Req;
                    end
                    RGN_GFX: begin
                        // addr[13] selects the byte lane; the word address
                        // closes the gap it leaves.
                        r_port2A   <= {w_head.addr[23:15], w_head.addr[14],
                                       w_head.addr[12:0]};
                        r_port2Ds  <= {w_head.addr[13], ~w_head.addr[13]};
                        r_port2D   <= {w_head.data, w_head.data};
                        r_port2Req <= ~r_port2Req;
                    end
                    RGN_PAL: begin
                        r_palWr   <= 1'b1;
                        r_palAddr <= w_head.addr[4:0];
                        r_palDat  <= w_head.data;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Overflow only when the write truly has nowhere to go: full with no pop.
    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_overflow <= 1'b0;
        end else if (r_capValid && w_fifoFull && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    // Download state register. downlPrev restarts at 0 so a download still
    // active when reset drops re-enters LOAD.
    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_downlPrev <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_downlPrev <= i_ioctl_downl;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_IDLE:  if (w_downlRise) w_stateNext = ST_LOAD;
            ST_LOAD:  if (w_downlFall) w_stateNext = ST_FLUSH;
            ST_FLUSH: begin
                if (w_downlRise) begin
                    w_stateNext = ST_LOAD;
                end else if (w_drained) begin
                    w_stateNext = ST_DONE;
                end
            end
            ST_DONE:  if (w_downlRise) w_stateNext = ST_LOAD;
            default:  w_stateNext = ST_IDLE;
        endcase
    end

    always_comb begin
        w_setLoaded     = (r_state == ST_FLUSH) && (w_stateNext == ST_DONE);
        w_coreResetNext = (r_state != ST_DONE) || i_user_reset || i_reset;
    end

    // rom_loaded survives later downloads; only reset clears it.
    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_romLoaded <= 1'b0;
        end else if (w_setLoaded) begin
            r_romLoaded <= 1'b1;
        end
    end

    always_ff @(posedge i_clk_sys) begin
        r_coreReset <= w_coreResetNext;
    end

    assign o_port1_req  = r_port1Req;
    assign o_port1_a    = r_port1A;
    assign o_port1_ds   = r_port1Ds;
    assign o_port1_d    = r_port1D;
    assign o_port2_req  = r_port2Req;
    assign o_port2_a    = r_port2A;
    assign o_port2_ds   = r_port2Ds;
    assign o_port2_d    = r_port2D;
    assign o_pal_wr     = r_palWr;
    assign o_pal_addr   = r_palAddr;
    assign o_pal_dat    = r_palDat;
    assign o_rom_loaded = r_romLoaded;
    assign o_core_reset = r_coreReset;
    assign o_overflow   = r_overflow;
    assign o_busy       = !w_fifoEmpty || !w_port1Idle || !w_port2Idle;

endmodule

// File: doc/rom_dl_ctrl.md
Name: rom_dl_ctrl

Overview:
Sequences the ioctl ROM download stream from data_io into the SDRAM download ports and the palette PROM write strobe, replacing the ad-hoc edge-toggle logic in the core top level. It decodes each byte's region, buffers bytes in a small FIFO, and issues toggle-handshake requests to sdram port1 (CPU ROMs) and port2 (GFX ROMs) only when the target port has acknowledged its previous request. It also owns the rom_loaded flag and the core reset sequencing.

Parameters:
FIFO_DEPTH, 4, byte buffer entries (power of 2, ≥2)
CPU_BASE, 25'h10000, first ioctl byte address of the CPU ROM region (64 KiB long)
PAL_BASE, 25'h20000, first ioctl byte address of the palette PROM region (32 bytes long)

Ports:
clk_sys  in  1  system clock (48 MHz)
reset  in  1  synchronous, active-high
user_reset  in  1  OSD/button reset request (status[0] | buttons[1])
ioctl_downl  in  1  download active
ioctl_wr  in  1  byte strobe (level; rising edge = new byte)
ioctl_addr  in  25  byte address
ioctl_dout  in  8  byte data
port1_req  out  1  toggle request to CPU ROM port
port1_ack  in  1  toggle ack
port1_a  out  23  word address
port1_ds  out  2  byte select {hi,lo}
port1_d  out  16  data, byte duplicated
port2_req / port2_ack / port2_a / port2_ds / port2_d: same widths, GFX ROM port
pal_wr  out  1  one-cycle palette write strobe
pal_addr  out  5  palette index
pal_dat  out  8  palette data
rom_loaded  out  1  sticky: a download has completed and drained
core_reset  out  1  reset to game core
busy  out  1  FIFO non-empty or any port pending
overflow  out  1  sticky: byte dropped because FIFO full

Behaviour:
- Reset: port1_req<=port1_ack, port2_req<=port2_ack (resync, no pending); port*_a/ds/d, pal_* =0; pal_wr=0; FIFO empty; rom_loaded=0; overflow=0; core_reset=1; state IDLE.
- Byte capture: ioctl_wr rising edge (registered previous value) while ioctl_downl=1 → push {region, addr, data} next cycle. Region: GFX if addr<CPU_BASE; CPU if CPU_BASE≤addr<CPU_BASE+64K; PAL if PAL_BASE≤addr<PAL_BASE+32; else DROP (not pushed). FIFO full at push → byte discarded, overflow<=1.
- Address mapping: CPU: off=addr−CPU_BASE; port1_a=off[23:1]; port1_ds={off[0],~off[0]}. GFX: port2_a={addr[23:15],addr[14],addr[12:0]}; port2_ds={addr[13],~addr[13]}. port*_d={data,data}.
- Issue: head entry pops only when its port idle (req==ack). Pop cycle registers a/ds/d and toggles req in the same edge; outputs stable until ack matches. PAL head pops unconditionally: pal_wr=1 for exactly one cycle with pal_addr=addr[4:0], pal_dat=data. Head blocks later entries (in-order).
- Push and pop in same cycle allowed; full+pop+push → accepted, no overflow.
- FSM: IDLE →(ioctl_downl rise) LOAD; LOAD →(ioctl_downl fall) FLUSH; FLUSH →(FIFO empty and both ports idle) DONE, rom_loaded<=1; DONE →(ioctl_downl rise) LOAD (rom_loaded stays 1). ioctl_downl falling then rising again within FLUSH → back to LOAD.
- core_reset = (state!=DONE) | user_reset | reset, registered (1-cycle latency).
- busy = FIFO non-empty | port1_req!=port1_ack | port2_req!=port2_ack.
- Acks arriving with no pending request have no effect (req unchanged).
- reset mid-download: FIFO flushed, in-flight request abandoned via req resync; rom_loaded cleared.

Decomposition:
- Package dl_pkg: region enum {GFX,CPU,PAL,DROP}; entry struct {region, addr[24:0], data[7:0]}; CPU_LEN=64K, PAL_LEN=32.
- Sub-module dl_fifo: synchronous FIFO of entries, parameter DEPTH, push/pop/full/empty.

Test Plan:
- GFX byte addr 0x02005 data 0x5A, ack after 3 cycles → port2_req toggles once; port2_a={0x00,0,0x0005}=0x00005, ds=2'b10... per addr[13]=1 → 2'b10, d=0x5A5A.
- CPU byte addr 0x10003 data 0xC3 → port1_a=1, ds=2'b10, d=0xC3C3; port2_req unchanged.
- Palette byte addr 0x2001F data 0x7E → pal_wr one cycle, pal_addr=31, pal_dat=0x7E; no port request.
- Hold port2_ack for 20 cycles, push 6 GFX bytes with DEPTH=4 → 1 in flight + 4 buffered, 1 dropped, overflow=1, order preserved.
- Full download then ioctl_downl fall with 2 pending → core_reset stays 1 until last ack; then rom_loaded=1, core_reset=0 next cycle; user_reset=1 → core_reset=1.
- reset asserted with port1 pending and 3 FIFO entries → busy=0 next cycle, rom_loaded=0, no further req toggles.
